mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Parametrised N-channel front end for the PSRAM memory controller (memCtrl). Replaces the hand-sequenced single-requester access logic in the top level.
- Requesters (CPU, VIC, DMA/test sequencers) post read/write transactions. The block arbitrates fixed-priority or round-robin and drives one transaction at a time into the memory controller.
- It tracks controller busy/data-ready, returns read data with a one-cycle ack per channel, and flags timeouts.

Parameters:
- NUM_CH, 2, number of requester channels (1..8).
- ADDR_W, 16, address width per channel.
- BANK_W, 6, bank width per channel.
- DATA_W, 8, data width.
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (channel 0 highest).
- TIMEOUT, 1023, max cycles waited for completion before abort; counter width = $clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock (same domain as memCtrl clkRAM).
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_CH  per-channel request level.
- req_write  in  NUM_CH  per-channel 1 = write, 0 = read.
- req_addr  in  NUM_CH*ADDR_W  flattened addresses; channel i at [i*ADDR_W +: ADDR_W].
- req_bank  in  NUM_CH*BANK_W  flattened banks.
- req_wdata  in  NUM_CH*DATA_W  flattened write data.
- ack  out  NUM_CH  one-cycle completion pulse for the granted channel.
- rdata  out  DATA_W  read data; valid in the ack cycle, held until the next read completes.
- err  out  1  high in the ack cycle if the transaction timed out.
- grant_id  out  $clog2(NUM_CH) (min 1)  index of the current or last granted channel.
- busy  out  1  high in any state other than IDLE.
- mem_cs  out  1  controller chip enable (memCtrl CS).
- mem_write  out  1  controller write select.
- mem_addr  out  ADDR_W  controller address.
- mem_bank  out  BANK_W  controller bank.
- mem_wdata  out  DATA_W  controller dataToWrite.
- mem_rdata  in  DATA_W  controller dataRead.
- mem_busy  in  1  controller o_busy.
- mem_data_ready  in  1  controller o_dataReady.

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE.
  - All outputs go to 0: ack, rdata, err, grant_id, busy, mem_cs, mem_write, mem_addr, mem_bank, mem_wdata.
  - Round-robin pointer last = NUM_CH-1, so channel 0 is served first.
  - Timeout counter = 0.
  - Reset mid-transaction aborts it immediately: mem_cs drops asynchronously and no ack is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req bit is set, select a winner.
  - RR_MODE=1: first set bit searching from last+1 upward, wrapping modulo NUM_CH.
  - RR_MODE=0: lowest set index.
  - Latch write/addr/bank/wdata of the winner into the mem_* registers; set grant_id; update last (RR only); go to ISSUE.
- ISSUE:
  - If mem_busy=0: assert mem_cs for exactly one cycle, clear the timeout counter, go to WAIT.
  - If mem_busy=1: stay and keep mem_cs=0; the timeout counter runs here too.
- WAIT:
  - Read completes on the first cycle with mem_data_ready=1. Capture mem_rdata into rdata.
  - Write completes on the first cycle with mem_busy=0 after at least one cycle of mem_busy=1 seen in WAIT.
  - Completion takes precedence over timeout in the same cycle.
  - Timeout counter increments each cycle. When it reaches TIMEOUT: set err=1, leave rdata unchanged, go to DONE.
- DONE:
  - ack[grant_id]=1 for one cycle, err valid; go to IDLE.
  - err is cleared on the next cycle.
- Throughput:
  - Minimum 4 cycles per transaction (grant, cs, completion, ack).
  - A new grant may occur the cycle after DONE.
  - No back-to-back grant in the DONE cycle itself.
- Request rules:
  - req is a level signal; a requester holds it until it sees ack.
  - req_* fields are sampled only at grant; later changes are ignored.
  - Dropping req after grant does not cancel: the transaction completes and ack still pulses.
  - A channel still holding req after its ack is eligible again. Under round-robin it waits behind other pending channels; under fixed priority it may win again immediately.
- Simultaneous events:
  - Multiple requests are resolved by the arbitration rule only; never more than one ack bit is set.
  - mem_data_ready during ISSUE is ignored.
- Starvation:
  - With all channels requesting continuously, round-robin grants each channel once per NUM_CH transactions.
  - Fixed priority may starve channels; this is allowed.
- NUM_CH=1: arbitration degenerates to always grant channel 0; grant_id width 1, value 0.

Test Plan:
- Single read: NUM_CH=2, req[0]=1, read, addr=16'hC000, bank=0. Model returns busy for 3 cycles, then data_ready with 8'h79. Expect mem_cs one pulse with mem_addr=C000, ack=2'b01, rdata=8'h79, err=0.
- Write then readback: ch1 writes 8'h79 to addr 49152; model raises busy for 2 cycles. Expect ack[1] one cycle after busy falls and mem_write=1 during cs. Then ch1 reads addr 49152 and gets rdata=8'h79.
- Round-robin fairness: RR_MODE=1, both req held high for 6 transactions. Expect grant_id sequence 0,1,0,1,0,1 and ack alternating.
- Fixed priority: RR_MODE=0, both req held high. Expect grant_id=0 every transaction; ch1 gets served only after req[0] drops.
- Timeout: TIMEOUT=15, read with the model never asserting data_ready. Expect ack with err=1 exactly 15 cycles after cs, rdata unchanged, FSM back in IDLE.
- Reset mid-operation: assert reset=0 in WAIT. Expect mem_cs=0, busy=0 and ack=0 immediately. After release, a new req[1] gets the first grant on channel 0 only if req[0] is also set.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   N-channel front end for the PSRAM memory controller. Requesters post
//   read/write transactions. One winner is chosen by round-robin or by fixed
//   priority and driven into the controller as a single transaction. The
//   block follows the controller's busy/data-ready handshake, returns read
//   data with a one-cycle per-channel ack, and aborts with err on timeout.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   req[NUM_CH]         : per-channel request level (held until ack)
//   req_write[NUM_CH]   : per-channel 1 = write, 0 = read
//   req_addr/bank/wdata : flattened per-channel fields, channel i at [i*W +: W]
//   ack[NUM_CH]         : one-cycle completion pulse for the granted channel
//   rdata               : read data, valid in the ack cycle, held afterwards
//   err                 : high in the ack cycle when the transaction timed out
//   grant_id            : index of the current or last granted channel
//   busy                : high whenever the FSM is not idle
//   mem_cs/write/addr/bank/wdata : controller command outputs
//   mem_rdata/busy/data_ready    : controller responses
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 16,
  parameter int BANK_W  = 6,
  parameter int DATA_W  = 8,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 1023,
  localparam int GID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*BANK_W-1:0] req_bank,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     err,
  output logic [GID_W-1:0]         grant_id,
  output logic                     busy,
  output logic                     mem_cs,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [BANK_W-1:0]        mem_bank,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_busy,
  input  logic                     mem_data_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0] TO_VAL = (CNT_W + 1)'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [GID_W-1:0]    r_last;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_seen_busy;
  logic [NUM_CH-1:0]   r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [GID_W-1:0]    r_gid;
  logic                r_busy;
  logic                r_mem_cs;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [BANK_W-1:0]   r_mem_bank;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic                w_found;
  logic                w_take;
  logic [GID_W-1:0]    w_win;
  int                  w_base;
  int                  w_dist;
  int                  w_best;

  logic                w_sel_write;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [BANK_W-1:0]   w_sel_bank;
  logic [DATA_W-1:0]   w_sel_wdata;

  logic                w_grant;
  logic                w_issue;
  logic                w_complete;
  logic                w_timeout;
  logic                w_fin;
  logic                w_done_evt;
  logic [CNT_W:0]      w_cnt_inc;
  logic                w_cnt_hit;
  logic [NUM_CH-1:0]   w_ack_nxt;

  // Winner selection: smallest circular distance from the search base wins.
  // Round-robin starts one past the last grant, fixed priority starts at 0.
  always_comb begin
    w_found = 1'b0;
    w_take  = 1'b0;
    w_win   = '0;
    w_best  = NUM_CH;
    w_dist  = 32'sd0;
    w_base  = (RR_MODE != 0) ? (int'(r_last) + 32'sd1) : 32'sd0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_dist = (k + NUM_CH - w_base) % NUM_CH;
      w_take = req[k] && (w_dist < w_best);
      w_win  = w_take ? GID_W'(k) : w_win;
      w_best = w_take ? w_dist : w_best;
    end
    w_found = (w_best < NUM_CH);
  end

  // Mux out the winning channel's transaction fields.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_bank  = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sel_write = (w_win == GID_W'(k)) ? req_write[k]                  : w_sel_write;
      w_sel_addr  = (w_win == GID_W'(k)) ? req_addr[k*ADDR_W +: ADDR_W]  : w_sel_addr;
      w_sel_bank  = (w_win == GID_W'(k)) ? req_bank[k*BANK_W +: BANK_W]  : w_sel_bank;
      w_sel_wdata = (w_win == GID_W'(k)) ? req_wdata[k*DATA_W +: DATA_W] : w_sel_wdata;
    end
  end

  // A write only counts as done once the controller has been seen busy and
  // then released; a read is done on the first data-ready.
  assign w_done_evt = r_mem_write ? (r_seen_busy && !mem_busy) : mem_data_ready;
  assign w_cnt_inc  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_cnt_hit  = (w_cnt_inc == TO_VAL);
  assign w_fin      = w_complete | w_timeout;

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_issue     = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!mem_busy) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end else if (w_cnt_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_WAIT: begin
        // Completion wins over a timeout landing in the same cycle.
        if (w_done_evt) begin
          w_complete  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_cnt_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // One-hot ack for the granted channel in the cycle the FSM enters DONE.
  always_comb begin
    w_ack_nxt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_ack_nxt[k] = w_fin && (r_gid == GID_W'(k));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last      <= GID_W'(NUM_CH - 1);
      r_cnt       <= '0;
      r_seen_busy <= 1'b0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_gid       <= '0;
      r_busy      <= 1'b0;
      r_mem_cs    <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_bank  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_ack    <= w_ack_nxt;
      r_err    <= w_timeout;
      r_mem_cs <= w_issue;
      r_busy   <= (w_state_nxt != S_IDLE);
      if (w_grant) begin
        r_mem_write <= w_sel_write;
        r_mem_addr  <= w_sel_addr;
        r_mem_bank  <= w_sel_bank;
        r_mem_wdata <= w_sel_wdata;
        r_gid       <= w_win;
        r_last      <= (RR_MODE != 0) ? w_win : r_last;
        r_cnt       <= '0;
        r_seen_busy <= 1'b0;
      end else if (w_issue) begin
        r_cnt       <= '0;
        r_seen_busy <= 1'b0;
      end else if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
        r_cnt       <= w_cnt_inc[CNT_W-1:0];
        r_seen_busy <= r_seen_busy | ((r_state == S_WAIT) && mem_busy);
      end else begin
        r_cnt       <= r_cnt;
        r_seen_busy <= r_seen_busy;
      end
      if (w_complete && !r_mem_write) begin
        r_rdata <= mem_rdata;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign grant_id  = r_gid;
  assign busy      = r_busy;
  assign mem_cs    = r_mem_cs;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_bank  = r_mem_bank;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter. Two instances share one behavioural
//   memory controller model: dut_a is round-robin, dut_b is fixed priority,
//   both with TIMEOUT=15. The model serves whichever instance sel_fp picks.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  a_req = 2'b00;
  logic [1:0]  b_req = 2'b00;
  logic [1:0]  req_write = 2'b00;
  logic [31:0] req_addr = 32'h0;
  logic [11:0] req_bank = 12'h0;
  logic [15:0] req_wdata = 16'h0;
  logic [7:0]  mem_rdata;
  logic        mem_busy;
  logic        mem_data_ready;

  logic [1:0]  a_ack, b_ack;
  logic [7:0]  a_rdata, b_rdata;
  logic        a_err, b_err;
  logic [0:0]  a_gid, b_gid;
  logic        a_busy, b_busy;
  logic        a_cs, b_cs;
  logic        a_wr, b_wr;
  logic [15:0] a_addr, b_addr;
  logic [5:0]  a_bank, b_bank;
  logic [7:0]  a_wdata, b_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model controls and observations.
  bit          sel_fp = 1'b0;
  int          m_busy_cycles = 3;
  bit          m_never_ready = 1'b0;
  logic        m_hold = 1'b0;
  logic        m_busy_int;
  bit          m_active;
  int          m_cnt;
  logic [7:0]  store [int];
  int          cyc = 0;
  int          cs_cnt = 0;
  int          cs_cyc = 0;
  logic        cap_wr;
  logic [15:0] cap_addr;
  logic [7:0]  cap_wdata;

  always #5 clk = ~clk;

  // Free-running cycle counter for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_busy = m_busy_int | m_hold;

  mem_bus_arbiter #(.NUM_CH(2), .ADDR_W(16), .BANK_W(6), .DATA_W(8),
                    .RR_MODE(1), .TIMEOUT(15)) dut_a (
    .clk(clk), .reset(reset), .req(a_req), .req_write(req_write),
    .req_addr(req_addr), .req_bank(req_bank), .req_wdata(req_wdata),
    .ack(a_ack), .rdata(a_rdata), .err(a_err), .grant_id(a_gid), .busy(a_busy),
    .mem_cs(a_cs), .mem_write(a_wr), .mem_addr(a_addr), .mem_bank(a_bank),
    .mem_wdata(a_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .mem_data_ready(mem_data_ready));

  mem_bus_arbiter #(.NUM_CH(2), .ADDR_W(16), .BANK_W(6), .DATA_W(8),
                    .RR_MODE(0), .TIMEOUT(15)) dut_b (
    .clk(clk), .reset(reset), .req(b_req), .req_write(req_write),
    .req_addr(req_addr), .req_bank(req_bank), .req_wdata(req_wdata),
    .ack(b_ack), .rdata(b_rdata), .err(b_err), .grant_id(b_gid), .busy(b_busy),
    .mem_cs(b_cs), .mem_write(b_wr), .mem_addr(b_addr), .mem_bank(b_bank),
    .mem_wdata(b_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .mem_data_ready(mem_data_ready));

  // Behavioural controller: busy for m_busy_cycles after cs, then data-ready
  // (reads) or storage update (writes).
  initial begin : mem_model
    m_busy_int     = 1'b0;
    mem_data_ready = 1'b0;
    mem_rdata      = 8'h00;
    m_active       = 1'b0;
    m_cnt          = 0;
    forever begin
      @(negedge clk);
      mem_data_ready = 1'b0;
      if (!reset) begin
        m_active   = 1'b0;
        m_busy_int = 1'b0;
      end else if (sel_fp ? b_cs : a_cs) begin
        cs_cnt++;
        cs_cyc     = cyc;
        cap_wr     = sel_fp ? b_wr : a_wr;
        cap_addr   = sel_fp ? b_addr : a_addr;
        cap_wdata  = sel_fp ? b_wdata : a_wdata;
        m_active   = 1'b1;
        m_cnt      = m_busy_cycles;
        m_busy_int = 1'b1;
      end else if (m_active) begin
        if (m_cnt > 1) begin
          m_cnt--;
        end else begin
          m_active   = 1'b0;
          m_busy_int = 1'b0;
          if (cap_wr) begin
            store[int'(cap_addr)] = cap_wdata;
          end else if (!m_never_ready) begin
            mem_data_ready = 1'b1;
            mem_rdata = store.exists(int'(cap_addr)) ? store[int'(cap_addr)] : 8'h00;
          end
        end
      end
    end
  end

  // Waits (bounded) for a non-zero ack on the chosen instance.
  task automatic wait_ack(input bit fp, input int budget, output logic [1:0] ackv,
                          output int n);
    bit hit;
    hit  = 1'b0;
    n    = 0;
    ackv = 2'b00;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      ackv = fp ? b_ack : a_ack;
      if (ackv != 2'b00) hit = 1'b1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_ack, a_rdata, a_err, a_gid, a_busy, a_cs, a_wr, a_addr, a_bank, a_wdata} !== 45'd0)
      $display("FAIL reset_a: got %h expected 0",
               {a_ack, a_rdata, a_err, a_gid, a_busy, a_cs, a_wr, a_addr, a_bank, a_wdata});
    n_checks++;
    if ({b_ack, b_rdata, b_err, b_gid, b_busy, b_cs, b_wr, b_addr, b_bank, b_wdata} !== 45'd0)
      $display("FAIL reset_b: got %h expected 0",
               {b_ack, b_rdata, b_err, b_gid, b_busy, b_cs, b_wr, b_addr, b_bank, b_wdata});
    if ({a_ack, a_rdata, a_err, a_gid, a_busy, a_cs, a_wr, a_addr, a_bank, a_wdata} !== 45'd0) n_fail++;
    if ({b_ack, b_rdata, b_err, b_gid, b_busy, b_cs, b_wr, b_addr, b_bank, b_wdata} !== 45'd0) n_fail++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_read;
    logic [1:0] ackv;
    int n, c0;
    store[32'hC000]   = 8'h79;
    m_busy_cycles     = 3;
    c0                = cs_cnt;
    req_write[0]      = 1'b0;
    req_addr[15:0]    = 16'hC000;
    req_bank[5:0]     = 6'd0;
    a_req[0]          = 1'b1;
    wait_ack(1'b0, 30, ackv, n);
    n_checks++; if (ackv !== 2'b01) begin n_fail++; $display("FAIL rd_ack: got %b expected 01", ackv); end
    n_checks++; if (a_rdata !== 8'h79) begin n_fail++; $display("FAIL rd_data: got %h expected 79", a_rdata); end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b expected 0", a_err); end
    n_checks++; if (n !== 6) begin n_fail++; $display("FAIL rd_latency: got %0d expected 6", n); end
    n_checks++; if (cs_cnt - c0 !== 1) begin n_fail++; $display("FAIL rd_cs_pulses: got %0d expected 1", cs_cnt - c0); end
    n_checks++; if ({cap_wr, cap_addr} !== 17'h0C000) begin n_fail++; $display("FAIL rd_cs_cmd: got %h expected 0c000", {cap_wr, cap_addr}); end
    a_req[0] = 1'b0;
    @(negedge clk);
    n_checks++; if ({a_ack, a_busy} !== 3'b000) begin n_fail++; $display("FAIL rd_after: got %b expected 000", {a_ack, a_busy}); end
  endtask

  task automatic test_write_readback;
    logic [1:0] ackv;
    int n;
    store[32'hC000]   = 8'h00;
    m_busy_cycles     = 2;
    req_write[1]      = 1'b1;
    req_addr[31:16]   = 16'd49152;
    req_bank[11:6]    = 6'd3;
    req_wdata[15:8]   = 8'h79;
    a_req[1]          = 1'b1;
    wait_ack(1'b0, 30, ackv, n);
    n_checks++; if (ackv !== 2'b10) begin n_fail++; $display("FAIL wr_ack: got %b expected 10", ackv); end
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL wr_latency: got %0d expected 5", n); end
    n_checks++; if ({cap_wr, cap_wdata} !== 9'h179) begin n_fail++; $display("FAIL wr_cs_cmd: got %h expected 179", {cap_wr, cap_wdata}); end
    n_checks++; if (store[32'hC000] !== 8'h79) begin n_fail++; $display("FAIL wr_store: got %h expected 79", store[32'hC000]); end
    n_checks++; if ({a_gid, a_bank, a_err} !== 8'b1_000011_0) begin n_fail++; $display("FAIL wr_gid_bank_err: got %b expected 10000110", {a_gid, a_bank, a_err}); end
    a_req[1] = 1'b0;
    @(negedge clk);
    m_busy_cycles = 3;
    req_write[1]  = 1'b0;
    a_req[1]      = 1'b1;
    wait_ack(1'b0, 30, ackv, n);
    n_checks++; if (ackv !== 2'b10) begin n_fail++; $display("FAIL rb_ack: got %b expected 10", ackv); end
    n_checks++; if (a_rdata !== 8'h79) begin n_fail++; $display("FAIL rb_data: got %h expected 79", a_rdata); end
    n_checks++; if (n !== 6) begin n_fail++; $display("FAIL rb_latency: got %0d expected 6", n); end
    a_req[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rr_fair;
    logic [1:0] ackv;
    int n;
    logic [0:0] eg;
    store[32'h0010] = 8'hA0;
    store[32'h0020] = 8'hB1;
    m_busy_cycles   = 1;
    req_write       = 2'b00;
    req_addr        = {16'h0020, 16'h0010};
    a_req           = 2'b11;
    for (int i = 0; i < 6; i++) begin
      eg = (i % 2 == 1) ? 1'b1 : 1'b0;
      wait_ack(1'b0, 30, ackv, n);
      n_checks++; if (a_gid !== eg) begin n_fail++; $display("FAIL rr_gid[%0d]: got %0d expected %0d", i, a_gid, eg); end
      n_checks++; if (ackv !== (eg ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, ackv, eg ? 2'b10 : 2'b01); end
      n_checks++; if (a_rdata !== (eg ? 8'hB1 : 8'hA0)) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", i, a_rdata, eg ? 8'hB1 : 8'hA0); end
    end
    a_req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_fixed_prio;
    logic [1:0] ackv;
    int n;
    sel_fp        = 1'b1;
    m_busy_cycles = 1;
    b_req         = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wait_ack(1'b1, 30, ackv, n);
      n_checks++; if ({b_gid, ackv} !== 3'b0_01) begin n_fail++; $display("FAIL fp_hi[%0d]: got %b expected 001", i, {b_gid, ackv}); end
    end
    b_req[0] = 1'b0;
    wait_ack(1'b1, 30, ackv, n);
    n_checks++; if ({b_gid, ackv} !== 3'b1_10) begin n_fail++; $display("FAIL fp_lo: got %b expected 110", {b_gid, ackv}); end
    n_checks++; if (b_rdata !== 8'hB1) begin n_fail++; $display("FAIL fp_data: got %h expected b1", b_rdata); end
    b_req = 2'b00;
    @(negedge clk);
    sel_fp = 1'b0;
  endtask

  task automatic test_issue_stall;
    logic [1:0] ackv;
    int n, c0;
    m_hold        = 1'b1;
    m_busy_cycles = 1;
    c0            = cs_cnt;
    a_req[0]      = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if ({cs_cnt - c0, a_busy} !== {32'd0, 1'b1}) begin n_fail++; $display("FAIL stall_no_cs: got cs=%0d busy=%b expected cs=0 busy=1", cs_cnt - c0, a_busy); end
    m_hold = 1'b0;
    wait_ack(1'b0, 30, ackv, n);
    n_checks++; if (ackv !== 2'b01) begin n_fail++; $display("FAIL stall_ack: got %b expected 01", ackv); end
    n_checks++; if (a_rdata !== 8'hA0) begin n_fail++; $display("FAIL stall_data: got %h expected a0", a_rdata); end
    a_req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    logic [1:0] ackv;
    int n;
    m_never_ready   = 1'b1;
    m_busy_cycles   = 2;
    req_addr[15:0]  = 16'h0030;
    a_req[0]        = 1'b1;
    wait_ack(1'b0, 40, ackv, n);
    n_checks++; if ({ackv, a_err} !== 3'b01_1) begin n_fail++; $display("FAIL to_ack_err: got %b expected 011", {ackv, a_err}); end
    n_checks++; if (a_rdata !== 8'hA0) begin n_fail++; $display("FAIL to_rdata_held: got %h expected a0", a_rdata); end
    n_checks++; if (cyc - cs_cyc !== 15) begin n_fail++; $display("FAIL to_latency: got %0d expected 15", cyc - cs_cyc); end
    a_req = 2'b00;
    @(negedge clk);
    n_checks++; if ({a_err, a_busy, a_ack} !== 4'b0000) begin n_fail++; $display("FAIL to_idle: got %b expected 0000", {a_err, a_busy, a_ack}); end
    m_never_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [1:0] ackv;
    int n;
    bit seen;
    m_never_ready   = 1'b1;
    m_busy_cycles   = 2;
    req_addr[31:16] = 16'h0020;
    req_addr[15:0]  = 16'h0010;
    a_req           = 2'b10;
    seen            = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (a_cs) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rm_cs_seen: got %b expected 1", seen); end
    reset = 1'b0;
    #1;
    n_checks++; if ({a_cs, a_busy, a_ack} !== 4'b0000) begin n_fail++; $display("FAIL rm_abort: got %b expected 0000", {a_cs, a_busy, a_ack}); end
    @(negedge clk);
    a_req         = 2'b11;
    m_never_ready = 1'b0;
    m_busy_cycles = 1;
    @(negedge clk);
    reset = 1'b1;
    wait_ack(1'b0, 30, ackv, n);
    n_checks++; if ({a_gid, ackv} !== 3'b0_01) begin n_fail++; $display("FAIL rm_first: got %b expected 001", {a_gid, ackv}); end
    a_req[0] = 1'b0;
    wait_ack(1'b0, 30, ackv, n);
    n_checks++; if ({a_gid, ackv, a_rdata} !== {1'b1, 2'b10, 8'hB1}) begin n_fail++; $display("FAIL rm_second: got %h expected 6b1", {a_gid, ackv, a_rdata}); end
    a_req = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_readback();
    test_rr_fair();
    test_fixed_prio();
    test_issue_stall();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
